// File: rtl/pair_split_rx.sv
// Serial-to-pair receiver: even-index bits land on mid1, odd-index bits on mid2,
// and completed pairs queue in a small FIFO behind a valid/ready handshake.
module pair_split_rx #(
    parameter int   DEPTH = 4,
    parameter logic PAD   = 1'b0
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   mid1,
    output logic                   mid2,
    output logic                   out_last,
    output logic                   out_odd,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {EVEN, ODD} phase_t;

    typedef struct packed {
        logic mid1;
        logic mid2;
        logic last;
        logic odd;
    } pair_t;

    phase_t          phase;
    logic            hold;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    pair_t           mem [DEPTH];
    pair_t           push_pair;
    pair_t           head;
    logic            in_xfer;
    logic            push;
    logic            pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot an ODD or closing bit needs.
    assign in_ready  = rst_n && ((count < FULL) || pop);
    assign in_xfer   = in_valid && in_ready;
    assign push      = in_xfer && ((phase == ODD) || in_last);

    always_comb begin
        // NOTE: both branches assign every field, so no latch can be inferred.
        if (phase == ODD) begin
            push_pair = '{mid1: hold, mid2: in_bit, last: in_last, odd: 1'b0};
        end else begin
            push_pair = '{mid1: in_bit, mid2: PAD, last: 1'b1, odd: 1'b1};
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {mid1, mid2, out_last, out_odd} = head;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            phase  <= EVEN;
            hold   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_xfer) begin
                if (phase == EVEN && !in_last) begin
                    hold  <= in_bit;
                    phase <= ODD;
                end else begin
                    phase <= EVEN;
                end
            end
            // DEPTH is a power of two, so the pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the pair storage has no reset; count gates every read of it.
    always_ff @(posedge clk1) begin
        if (push) mem[wr_ptr] <= push_pair;
    end

endmodule
